commit_trace_buf: RTL and testbench

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

---
 rtl/commit_trace_buf.sv | 143 ++++++++++++++
 tb/tb_commit_trace_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: captures retiring writeback-stage instructions into a
// small FIFO of trace records and streams them out over a valid/ready port.
module commit_trace_buf #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_SIZE = 5,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validW,
  input  logic                      regWriteW,
  input  logic                      memWriteW,
  input  logic                      finishW,
  input  logic [REG_SIZE-1:0]       writeRegW,
  input  logic [XLEN-1:0]           resultW,
  input  logic [XLEN-1:0]           ALUResultW,
  input  logic [XLEN-1:0]           writeDataW,
  input  logic [XLEN-1:0]           pcW,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [1:0]                trc_kind,
  output logic [31:0]               trc_num,
  output logic [XLEN-1:0]           trc_pc,
  output logic [XLEN-1:0]           trc_addr,
  output logic [XLEN-1:0]           trc_data,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow,
  output logic [15:0]               dropped,
  output logic                      done
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]      kind;
    logic [31:0]     num;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            rec_d;
  rec_t            head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     dropped_q, dropped_d;
  state_e          state_q, state_d;
  logic            capture, pop, push, drop, full;

  always_comb begin
    pop     = (occ_q != '0) && trc_ready;
    capture = (state_q == S_RUN) && validW;
    full    = (occ_q == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;

    rec_d      = '0;
    rec_d.num  = retire_cnt_q;
    rec_d.pc   = pcW + XLEN'(4);
    if (regWriteW && (writeRegW != '0)) begin
      rec_d.kind = 2'd1;
      rec_d.addr = XLEN'(writeRegW);
      rec_d.data = resultW;
    end else if (memWriteW) begin
      rec_d.kind = 2'd2;
      rec_d.addr = ALUResultW;
      rec_d.data = writeDataW;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Dropped retires still consume a sequence number.
    retire_cnt_d = capture ? retire_cnt_q + 32'd1 : retire_cnt_q;
    overflow_d   = overflow_q | drop;
    dropped_d    = (drop && (dropped_q != '1)) ? dropped_q + 16'd1 : dropped_q;

    state_d = state_q;
    case (state_q)
      S_RUN:   if (finishW) state_d = S_DRAIN;
      S_DRAIN: if (occ_q == '0) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      retire_cnt_q <= 32'd1;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
      state_q      <= S_RUN;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      retire_cnt_q <= retire_cnt_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  // Head fields are forced to zero whenever the FIFO is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    trc_valid = (occ_q != '0);
    trc_kind  = trc_valid ? head.kind : '0;
    trc_num   = trc_valid ? head.num  : '0;
    trc_pc    = trc_valid ? head.pc   : '0;
    trc_addr  = trc_valid ? head.addr : '0;
    trc_data  = trc_valid ? head.data : '0;
    occupancy = occ_q;
    overflow  = overflow_q;
    dropped   = dropped_q;
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf: table of single retires plus sequences
// for overflow, full-FIFO streaming, async reset and finish/drain.
module tb_commit_trace_buf;

  logic        clk, reset;
  logic        validW, regWriteW, memWriteW, finishW;
  logic [4:0]  writeRegW;
  logic [31:0] resultW, ALUResultW, writeDataW, pcW;
  logic        trc_valid, trc_ready;
  logic [1:0]  trc_kind;
  logic [31:0] trc_num, trc_pc, trc_addr, trc_data;
  logic [3:0]  occupancy;
  logic        overflow;
  logic [15:0] dropped;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_buf #(.XLEN(32), .REG_SIZE(5), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .validW(validW), .regWriteW(regWriteW), .memWriteW(memWriteW), .finishW(finishW),
    .writeRegW(writeRegW), .resultW(resultW), .ALUResultW(ALUResultW),
    .writeDataW(writeDataW), .pcW(pcW),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_kind(trc_kind), .trc_num(trc_num), .trc_pc(trc_pc),
    .trc_addr(trc_addr), .trc_data(trc_data),
    .occupancy(occupancy), .overflow(overflow), .dropped(dropped), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [1:0]  ekind;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic rw, input logic mw, input logic [4:0] wr,
                            input logic [31:0] res, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [31:0] pc);
    validW     = 1'b1;
    regWriteW  = rw;
    memWriteW  = mw;
    writeRegW  = wr;
    resultW    = res;
    ALUResultW = alu;
    writeDataW = wd;
    pcW        = pc;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_occ"},   occupancy, 0);
    chk({tag, "_valid"}, trc_valid, 0);
    chk({tag, "_kind"},  trc_kind,  0);
    chk({tag, "_num"},   trc_num,   0);
    chk({tag, "_pc"},    trc_pc,    0);
    chk({tag, "_addr"},  trc_addr,  0);
    chk({tag, "_data"},  trc_data,  0);
    chk({tag, "_ovf"},   overflow,  0);
    chk({tag, "_drop"},  dropped,   0);
    chk({tag, "_done"},  done,      0);
  endtask

  initial begin
    logic [31:0] exp_num;
    int          nrec;
    bit          seen_zero;

    vecs[0] = '{1'b1, 1'b0, 5'd3,  32'h2A,       32'h0,        32'h0,        32'h100,
                2'd1, 32'h3,  32'h2A,       32'h104};
    vecs[1] = '{1'b0, 1'b1, 5'd0,  32'h0,        32'h80,       32'h55,       32'h200,
                2'd2, 32'h80, 32'h55,       32'h204};
    vecs[2] = '{1'b1, 1'b0, 5'd0,  32'h99,       32'h0,        32'h0,        32'h204,
                2'd0, 32'h0,  32'h0,        32'h208};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'h77,       32'h40,       32'h11,       32'h300,
                2'd2, 32'h40, 32'h11,       32'h304};
    vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 32'h1234,     32'h5678,     32'h10,
                2'd1, 32'h1F, 32'hDEADBEEF, 32'h14};
    vecs[5] = '{1'b0, 1'b1, 5'd7,  32'h1,        32'hFFFFFFFF, 32'hA5A5A5A5, 32'hFFFFFFFC,
                2'd2, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 5'd9,  32'h123,      32'h44,       32'h66,       32'h7FFFFFFE,
                2'd0, 32'h0,  32'h0,        32'h80000002};

    reset = 1'b0; validW = 1'b0; regWriteW = 1'b0; memWriteW = 1'b0; finishW = 1'b0;
    writeRegW = '0; resultW = '0; ALUResultW = '0; writeDataW = '0; pcW = '0;
    trc_ready = 1'b1;
    #12;
    chk_all_reset("por");
    reset = 1'b1;
    step();

    // Single retires, one record each, popped immediately.
    exp_num = 32'd1;
    for (int i = 0; i < 7; i++) begin
      set_retire(vecs[i].rw, vecs[i].mw, vecs[i].wr, vecs[i].res,
                 vecs[i].alu, vecs[i].wd, vecs[i].pc);
      step();
      validW = 1'b0;
      chk($sformatf("v%0d_valid", i), trc_valid, 1);
      chk($sformatf("v%0d_kind", i),  trc_kind,  vecs[i].ekind);
      chk($sformatf("v%0d_num", i),   trc_num,   exp_num);
      chk($sformatf("v%0d_addr", i),  trc_addr,  vecs[i].eaddr);
      chk($sformatf("v%0d_data", i),  trc_data,  vecs[i].edata);
      chk($sformatf("v%0d_pc", i),    trc_pc,    vecs[i].epc);
      exp_num++;
      step();
      if (i == 0) begin
        chk("v0_pop_occ", occupancy, 0);
        chk("v0_pop_valid", trc_valid, 0);
      end
    end

    // Reset pulse between edges, then overflow with ten retires and no ready.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    trc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_retire(1'b1, 1'b0, 5'd1, 32'(i + 1), 32'h0, 32'h0, 32'(i * 4));
      step();
    end
    validW = 1'b0;
    chk("ovf_occ",   occupancy, 8);
    chk("ovf_flag",  overflow,  1);
    chk("ovf_drop",  dropped,   2);
    chk("ovf_num",   trc_num,   1);
    chk("ovf_data",  trc_data,  1);
    step(); step(); step();
    chk("stall_num",  trc_num,  1);
    chk("stall_data", trc_data, 1);
    chk("stall_pc",   trc_pc,   4);
    trc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_num", i), trc_num, 32'(i + 1));
      step();
    end
    chk("drained_occ", occupancy, 0);
    set_retire(1'b1, 1'b0, 5'd2, 32'h5, 32'h0, 32'h0, 32'h0);
    step();
    validW = 1'b0;
    chk("after_drop_num", trc_num, 11);
    step();

    // Fill to full, then push and pop every cycle.
    trc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_retire(1'b0, 1'b1, 5'd0, 32'h0, 32'(i), 32'(i), 32'h40);
      step();
    end
    chk("full_occ", occupancy, 8);
    chk("full_head", trc_num, 12);
    trc_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("stream%0d_occ", k), occupancy, 8);
      chk($sformatf("stream%0d_num", k), trc_num, 32'(12 + k));
    end
    validW = 1'b0;
    chk("stream_drop", dropped, 2);

    // Asynchronous reset with a full FIFO and overflow set.
    chk("pre_rst_ovf", overflow, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_reset("async");
    #2;
    reset = 1'b1;
    step();

    // Finish with three entries queued; retire on the finish cycle is kept.
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, 1'b0, 5'd4, 32'(100 + i), 32'h0, 32'h0, 32'h800);
      step();
    end
    chk("fin_occ", occupancy, 3);
    set_retire(1'b1, 1'b0, 5'd4, 32'd103, 32'h0, 32'h0, 32'h800);
    finishW   = 1'b1;
    trc_ready = 1'b1;
    exp_num   = 32'd1;
    nrec      = 0;
    seen_zero = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (trc_valid) begin
        chk($sformatf("fin_rec%0d_num", nrec), trc_num, exp_num);
        exp_num++;
        nrec++;
      end
      if (occupancy == 0) begin
        chk("done_at_empty", done, 0);
        step();
        chk("done_after_empty", done, 1);
        seen_zero = 1'b1;
        break;
      end
      step();
      finishW = 1'b0;
    end
    if (!seen_zero) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: occupancy 0x%0h never reached 0x0", occupancy);
    end
    chk("fin_records", nrec, 4);
    finishW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("done%0d_flag", i),  done,      1);
      chk($sformatf("done%0d_occ", i),   occupancy, 0);
      chk($sformatf("done%0d_valid", i), trc_valid, 0);
    end
    validW  = 1'b0;
    finishW = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
